// File: rtl/snd_pkg.sv
// snd_pkg: shared definitions for the sound mixer slice.
//   - default voice count, ROM address width and accumulator width
//   - sweep FSM state codes and the mix_state_t enum built on them
//   - sat16(): clamps a wide signed mix value to a 16-bit DAC word
//   - start/end ROM addresses of the sound effects stored in the ROM
package snd_pkg;

  localparam int NV_DEF   = 4;
  localparam int AW_DEF   = 15;
  localparam int ACCW_DEF = 20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_ACC  = 3'd3;
  localparam logic [2:0] ST_SAT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    WAIT = ST_WAIT,
    ACC  = ST_ACC,
    SAT  = ST_SAT
  } mix_state_t;

  // Sound effect locations in the shared 8-bit sound ROM (inclusive ranges).
  localparam logic [AW_DEF-1:0] SND_TICTAC_START    = 15'h0000;
  localparam logic [AW_DEF-1:0] SND_TICTAC_END      = 15'h03FF;
  localparam logic [AW_DEF-1:0] SND_EXPLOSION_START = 15'h0400;
  localparam logic [AW_DEF-1:0] SND_EXPLOSION_END   = 15'h2BFF;
  localparam logic [AW_DEF-1:0] SND_PICK_ITEM_START = 15'h2C00;
  localparam logic [AW_DEF-1:0] SND_PICK_ITEM_END   = 15'h33FF;
  localparam logic [AW_DEF-1:0] SND_OUCH_START      = 15'h3400;
  localparam logic [AW_DEF-1:0] SND_OUCH_END        = 15'h47FF;
  localparam logic [AW_DEF-1:0] SND_CRI_START       = 15'h4800;
  localparam logic [AW_DEF-1:0] SND_CRI_END         = 15'h5FFF;

  // Clamp a signed mix value into the 16-bit two's complement DAC range.
  function automatic logic [15:0] sat16(input logic signed [31:0] acc);
    if (acc > 32'sd32767) begin
      return 16'h7FFF;
    end else if (acc < -32'sd32768) begin
      return 16'h8000;
    end else begin
      return acc[15:0];
    end
  endfunction

endpackage

// File: rtl/snd_mixer_if.sv
// snd_mixer_if: read port of the shared sound ROM.
//   rom_addr : address driven by the mixer (master)
//   rom_data : signed 8-bit sample returned by the ROM (slave), one cycle later
interface snd_mixer_if
  import snd_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/snd_voice.sv
// snd_voice: state of one playback voice.
//   trig, start_addr, end_addr : start request; the range is captured with the trigger
//   apply                      : mixer is idle, a pending start may take effect
//   step                       : the mixer has just consumed this voice's sample
//   addr, active               : current ROM address and playing flag
module snd_voice
  import snd_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          aud_mclk,
  input  logic          reset_n,
  input  logic          trig,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          apply,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          active
);

  logic          pending_q, pending_d;
  logic          active_q, active_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] endr_q, endr_d;
  // Range captured at trigger time so a deferred start uses the requested sound.
  logic [AW-1:0] nstart_q, nstart_d;
  logic [AW-1:0] nend_q, nend_d;

  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    addr_d    = addr_q;
    endr_d    = endr_q;
    nstart_d  = nstart_q;
    nend_d    = nend_q;
    if (apply && pending_q) begin
      pending_d = 1'b0;
      active_d  = 1'b1;
      addr_d    = nstart_q;
      endr_d    = nend_q;
    end else if (step && active_q) begin
      // start > end also stops after the first sample; the address wraps naturally.
      if (addr_q >= endr_q) begin
        active_d = 1'b0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
    // A trigger arriving together with apply stays pending for the next idle cycle.
    if (trig) begin
      pending_d = 1'b1;
      nstart_d  = start_addr;
      nend_d    = end_addr;
    end
  end

  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      active_q  <= 1'b0;
      addr_q    <= '0;
      endr_q    <= '0;
      nstart_q  <= '0;
      nend_q    <= '0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      addr_q    <= addr_d;
      endr_q    <= endr_d;
      nstart_q  <= nstart_d;
      nend_q    <= nend_d;
    end
  end

  assign addr   = addr_q;
  assign active = active_q;

endmodule

// File: rtl/snd_mixer.sv
// snd_mixer: polyphonic sample player and mixer feeding the codec DAC.
//   aud_mclk, reset_n          : codec master clock, async active-low reset
//   data_ena                   : codec requests a new sample (starts one sweep)
//   trig/start_addr/end_addr   : per-voice start pulse and inclusive ROM range
//   volume                     : per-voice 4-bit gain, read while sweeping
//   rom                        : shared sound ROM read port (1-cycle latency)
//   dac_data_l/dac_data_r      : saturated mix, identical on both channels
//   voice_active               : per-voice playing flags
//   overrun                    : pulse when data_ena arrives mid-sweep
// Each sweep visits every voice for three cycles (ADDR, WAIT, ACC) so the DAC
// update always lands 3*NV+2 cycles after data_ena.
module snd_mixer
  import snd_pkg::*;
#(
  parameter int NV   = NV_DEF,
  parameter int AW   = AW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic             aud_mclk,
  input  logic             reset_n,
  input  logic             data_ena,
  input  logic [NV-1:0]    trig,
  input  logic [NV*AW-1:0] start_addr,
  input  logic [NV*AW-1:0] end_addr,
  input  logic [NV*4-1:0]  volume,
  snd_mixer_if.master      rom,
  output logic [15:0]      dac_data_l,
  output logic [15:0]      dac_data_r,
  output logic [NV-1:0]    voice_active,
  output logic             overrun
);

  localparam int CW = (NV > 1) ? $clog2(NV) : 1;
  localparam logic [CW-1:0] LAST_V = CW'(NV - 1);

  mix_state_t             state_q, state_d;
  logic [CW-1:0]          cur_q, cur_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [AW-1:0]          rom_addr_q, rom_addr_d;
  logic [15:0]            dac_q, dac_d;
  logic                   overrun_q, overrun_d;

  logic [AW-1:0]          v_addr [NV];
  logic [3:0]             v_vol  [NV];
  logic [NV-1:0]          v_active;
  logic [NV-1:0]          v_step;
  logic                   v_apply;

  logic signed [12:0]     smp_x, vol_x, prod;
  logic signed [ACCW-1:0] term;

  // Pending starts only take effect while no sweep is in flight.
  assign v_apply = (state_q == IDLE);

  for (genvar i = 0; i < NV; i++) begin : g_voice
    assign v_vol[i]  = volume[i*4 +: 4];
    assign v_step[i] = (state_q == ACC) && (cur_q == CW'(i));

    snd_voice #(.AW(AW)) u_voice (
      .aud_mclk   (aud_mclk),
      .reset_n    (reset_n),
      .trig       (trig[i]),
      .start_addr (start_addr[i*AW +: AW]),
      .end_addr   (end_addr[i*AW +: AW]),
      .apply      (v_apply),
      .step       (v_step[i]),
      .addr       (v_addr[i]),
      .active     (v_active[i])
    );
  end

  // sample * gain fits 13 bits signed; <<4 places volume 15 at 15/16 of {sample, 8'b0}.
  assign smp_x = {{5{rom.rom_data[7]}}, rom.rom_data};
  assign vol_x = {9'b0, v_vol[cur_q]};
  assign prod  = smp_x * vol_x;
  assign term  = {{(ACCW-17){prod[12]}}, prod, 4'b0000};

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    rom_addr_d = rom_addr_q;
    dac_d      = dac_q;
    overrun_d  = data_ena && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (data_ena) begin
          state_d = ADDR;
          cur_d   = '0;
          acc_d   = '0;
        end
      end
      ADDR: begin
        rom_addr_d = v_addr[cur_q];
        state_d    = WAIT;
      end
      WAIT: begin
        state_d = ACC;
      end
      ACC: begin
        if (v_active[cur_q]) begin
          acc_d = acc_q + term;
        end
        if (cur_q == LAST_V) begin
          state_d = SAT;
        end else begin
          cur_d   = cur_q + 1'b1;
          state_d = ADDR;
        end
      end
      SAT: begin
        dac_d   = sat16(32'(acc_q));
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aud_mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      acc_q      <= '0;
      rom_addr_q <= '0;
      dac_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      rom_addr_q <= rom_addr_d;
      dac_q      <= dac_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign dac_data_l   = dac_q;
  assign dac_data_r   = dac_q;
  assign voice_active = v_active;
  assign overrun      = overrun_q;

endmodule

// File: doc/snd_mixer.md
Name: snd_mixer

Overview:
- Polyphonic sample player and mixer between the sound-trigger logic and the codec's DAC data inputs; runs on aud_mclk.
- Holds NV independent voices, each playing an inclusive address range from the shared 8-bit sound ROM.
- Time-multiplexes the single ROM read port across all voices once per codec sample period (data_ena).
- Scales each voice by its volume, sums and saturates, and drives dac_data_l/dac_data_r.

Parameters:
- NV, 4, number of voices.
- AW, 15, sound ROM address width.
- ACCW, 20, signed mix accumulator width.

Ports:
- aud_mclk  input  1  codec master clock (~12 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- data_ena  input  1  one-cycle pulse from codec: new sample required.
- trig  input  NV  one-cycle start pulse per voice, already resynchronised and edge-detected.
- start_addr  input  NV*AW  per-voice first ROM address, voice i at bits [i*AW +: AW], sampled on trig.
- end_addr  input  NV*AW  per-voice last ROM address (inclusive), sampled on trig.
- volume  input  NV*4  per-voice unsigned gain 0..15, read live during the sweep.
- rom_addr  output  AW  ROM read address.
- rom_data  input  8  ROM data, signed two's complement, valid 1 cycle after rom_addr.
- dac_data_l  output  16  mixed sample, left.
- dac_data_r  output  16  mixed sample, right (always equal to left).
- voice_active  output  NV  voice i currently playing.
- overrun  output  1  one-cycle pulse when data_ena arrives while a sweep is still running.

Behaviour:
- Reset (async): all outputs 0, all voices inactive, pending bits cleared, FSM in IDLE, accumulator 0.
- Trigger handling:
  - trig[i] sets pending[i] in any state; a new trig ORs into an already-set pending bit.
  - In IDLE, each pending voice loads addr[i] <= start_addr and endr[i] <= end_addr, sets active[i]=1 and clears pending[i]; voice_active rises the next cycle.
  - Retriggering an active voice restarts it from the new start address.
- FSM states: IDLE, ADDR, WAIT, ACC, SAT.
  - IDLE -> ADDR on data_ena (cursor v=0, acc=0); pending bits are applied in this same cycle.
  - ADDR: drive rom_addr <= addr[v].
  - WAIT: one ROM latency cycle.
  - ACC:
    - If active[v]: acc += sext(rom_data * volume[v]) << 4.
    - If addr[v] >= endr[v]: active[v] <= 0; else addr[v] += 1.
    - Inactive voices add 0 but still take three cycles, so timing is fixed.
    - Then v == NV-1 ? SAT : ADDR with v+1.
  - SAT: dac_data_l = dac_data_r = clamp(acc, -32768, 32767); -> IDLE.
- Latency: dac outputs update exactly 3*NV+2 cycles after data_ena (14 for NV=4). Outputs hold between updates.
- Arithmetic:
  - One voice at volume 15 gives 15/16 of {sample, 8'b0}.
  - Worst-case sum is NV*(-128*15*16) = -122880, which fits ACCW=20 signed.
- Boundaries:
  - start == end: one sample is played, then the voice goes inactive.
  - start > end: the start sample is played, then the voice goes inactive.
  - addr[v] = 2^AW-1 with a larger end: the address wraps to 0 (unsupported content, no error).
  - data_ena outside IDLE: ignored and overrun pulses; the sweep continues unaffected.
  - trig during a sweep: deferred to the next IDLE cycle and does not disturb the current sweep.
  - Reset mid-sweep: everything returns to reset values immediately, with no partial dac update.
- The sweep start does not depend on voice_active: with all voices idle, a sweep still runs and outputs 0.

Decomposition:
- Package snd_pkg:
  - NV, AW, ACCW defaults.
  - State enum mix_state_t {IDLE, ADDR, WAIT, ACC, SAT}.
  - Function sat16(acc) returning the clamped 16-bit value.
  - Sound address localparams: tictac/explosion/pick_item/ouch/cri start and end.
- Sub-module snd_voice, instantiated NV times, holding per voice:
  - pending, active, addr and endr registers.
  - Load on apply, advance/deactivate on step.
  - Outputs addr and active.
- snd_mixer keeps the FSM, cursor, accumulator, rom_addr mux and saturation.

Test Plan:
- Reset then data_ena with no triggers: after 14 cycles dac_data_l/r = 0x0000, voice_active = 0, overrun = 0.
- trig[0] with start=100, end=102, vol=15, ROM[100..102] = 0x10, 0x7F, 0x80: successive data_ena give dac = 0x0F00, 0x7710, 0x8800; voice_active[0] falls after the third sweep, and the fourth sweep gives 0x0000.
- Voices 0..3 all looping ROM value 0x7F, vol=15 -> sum 0x1DC40 saturates to 0x7FFF. All on 0x80 -> -122880 saturates to 0x8000.
- Retrigger voice 1 mid-play (addr at 500, new start 20): the next sweep reads address 20; trig asserted during ADDR of voice 1 is applied only at the following IDLE.
- data_ena asserted 5 cycles after a previous data_ena: overrun pulses once, and the dac update still occurs at cycle 14 of the first sweep.
- reset_n low during WAIT of voice 2 with three voices active: outputs and voice_active go to 0 at once; after release, data_ena yields 0x0000.
